// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame geometry and a
// width helper for the oversampling counters. Also used by the receiver.
package uart_pkg;

  // State encoding is fixed; the receiver and any debug taps rely on it.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int NUM_TICKS          = 16;  // TICK pulses per bit period
  localparam int DATA_BITS_DEFAULT  = 8;   // payload bits per frame
  localparam int STOP_TICKS_DEFAULT = 16;  // one stop bit

  // Counter width that can hold 0..max(a,b)-1, never narrower than 1 bit.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_tick_if.sv
// Host-side handshake of the tick-driven UART transmitter.
interface uart_tx_tick_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEFAULT
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] din;
  logic                 tx;
  logic                 busy;
  logic                 tx_done_tick;

  // Host / echo logic side.
  modport master (
    output tx_start, din,
    input  tx, busy, tx_done_tick
  );

  // Transmitter side.
  modport slave (
    input  tx_start, din,
    output tx, busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_tick.sv
// 8N1-style UART transmitter paced purely by the 16x baud TICK.
// The frame is serialized LSB first; every output is registered.
module uart_tx_tick #(
  parameter int DATA_BITS  = uart_pkg::DATA_BITS_DEFAULT,
  parameter int NUM_TICKS  = uart_pkg::NUM_TICKS,
  parameter int STOP_TICKS = uart_pkg::STOP_TICKS_DEFAULT
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           TICK,
  uart_tx_tick_if.slave  bus
);
  import uart_pkg::*;

  localparam int SW = cnt_w(NUM_TICKS, STOP_TICKS);
  localparam int NW = cnt_w(DATA_BITS, 1);

  localparam logic [SW-1:0] S_BIT_END  = SW'(NUM_TICKS - 1);
  localparam logic [SW-1:0] S_STOP_END = SW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // State and datapath registers; reset drives the line high at once.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and registered-output logic; without TICK nothing advances.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          // A TICK in this cycle is deliberately not counted.
          sh_d    = bus.din;
          s_d     = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (TICK) begin
          if (s_q == S_BIT_END) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
            tx_d    = sh_q[0];
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (TICK) begin
          if (s_q == S_BIT_END) begin
            s_d  = '0;
            sh_d = sh_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              n_d  = n_q + 1'b1;
              tx_d = sh_q[1];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (TICK) begin
          if (s_q == S_STOP_END) begin
            s_d     = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx           = tx_q;
  assign bus.busy         = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Randomized bench for uart_tx_tick: a frame-level reference model predicts
// tx/busy/tx_done_tick every cycle, and a tick-counting decoder recovers
// the transmitted bytes from the line.
module tb_uart_tx_tick;
  import uart_pkg::*;

  localparam int DB    = 8;
  localparam int NT    = 16;
  localparam int ST    = 16;
  localparam int FRAME = NT * (1 + DB) + ST;

  logic CLK = 1'b0;
  logic reset;
  logic TICK;

  uart_tx_tick_if #(.DATA_BITS(DB)) bus ();

  uart_tx_tick #(.DATA_BITS(DB), .NUM_TICKS(NT), .STOP_TICKS(ST)) dut (
    .CLK   (CLK),
    .reset (reset),
    .TICK  (TICK),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a frame is a list of DB+2 line levels; the line shows
  // level floor(k/NT) after k ticks, and the frame ends after FRAME ticks.
  bit            m_act  = 1'b0;
  int            m_k    = 0;
  logic [DB+1:0] m_frm  = '1;
  bit            m_done = 1'b0;

  always @(posedge CLK) begin
    if (reset) begin
      m_act  <= 1'b0;
      m_k    <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_act) begin
        if (bus.tx_start) begin
          m_act <= 1'b1;
          m_k   <= 0;
          m_frm <= {1'b1, bus.din, 1'b0};
        end
      end else if (TICK) begin
        m_k <= m_k + 1;
        if (m_k + 1 == FRAME) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  function automatic logic [2:0] exp_out();
    int idx;
    idx = m_k / NT;
    if (idx > DB + 1) idx = DB + 1;
    return {(m_act ? m_frm[idx] : 1'b1), m_act, m_done};
  endfunction

  // Bench-side observation state.
  bit          chk_en = 1'b0;
  int          cyc = 0, tick_cnt = 0, tick_per = 4;
  int          done_cnt = 0, last_done_cyc = 0, last_acc_cyc = 0;
  bit          prev_busy = 1'b0;
  bit          dec_on = 1'b0;
  int          dec_k = 0, dec_cnt = 0;
  logic [DB-1:0] dec_byte = '0, last_dec = '0;

  // One cycle: observe at negedge, then drive the next TICK.
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (chk_en) chk("line", {29'd0, bus.tx, bus.busy, bus.tx_done_tick}, {29'd0, exp_out()});
    if (bus.tx_done_tick) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (!prev_busy && bus.busy) begin
      last_acc_cyc = cyc;
      dec_on = 1'b1;
      dec_k = 0;
      dec_byte = '0;
    end else if (dec_on) begin
      if (TICK) begin
        dec_k++;
        if (dec_k == NT / 2) chk("start_bit", bus.tx, 1'b0);
        if (dec_k % NT == NT / 2 && dec_k > NT && dec_k < NT * (DB + 1))
          dec_byte[dec_k / NT - 1] = bus.tx;
        if (dec_k == NT * (DB + 1) + ST / 2) chk("stop_bit", bus.tx, 1'b1);
      end
      if (!bus.busy) begin
        dec_on = 1'b0;
        if (dec_k == FRAME) begin
          dec_cnt++;
          last_dec = dec_byte;
        end
      end
    end
    prev_busy = bus.busy;
    tick_cnt++;
    TICK = (tick_cnt % tick_per == 0);
  endtask

  // Pulse tx_start for one cycle with tick phase realigned.
  task automatic send(input logic [DB-1:0] d);
    step();
    bus.tx_start = 1'b1;
    bus.din = d;
    tick_cnt = 0;
    TICK = 1'b0;
    step();
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (done_cnt < target) chk("timeout", done_cnt, target);
  endtask

  initial begin
    int base, d1, dcnt0;
    logic [DB-1:0] d;
    reset = 1'b1;
    TICK = 1'b0;
    bus.tx_start = 1'b0;
    bus.din = '0;
    repeat (3) step();
    chk("reset_state", {bus.tx, bus.busy, bus.tx_done_tick}, 3'b100);
    reset = 1'b0;
    chk_en = 1'b1;

    // Idle with ticks running and no request.
    repeat (1000) step();
    chk("idle_done", done_cnt, 0);
    chk("idle_busy", bus.busy, 1'b0);

    // 0x55 at TICK every 4 CLKs.
    tick_per = 4;
    send(8'h55);
    wait_done(1, 800);
    chk("lat_55", last_done_cyc - last_acc_cyc, 640);
    chk("dec_55", last_dec, 8'h55);
    repeat (100) step();
    chk("one_done_55", done_cnt, 1);

    // 0xA3 with tx_start held for two frames.
    base = done_cnt;
    dcnt0 = dec_cnt;
    step();
    bus.tx_start = 1'b1;
    bus.din = 8'hA3;
    tick_cnt = 0;
    TICK = 1'b0;
    wait_done(base + 1, 800);
    d1 = last_done_cyc;
    chk("dec_a3_1", last_dec, 8'hA3);
    step();
    chk("b2b_gap", last_acc_cyc - d1, 1);
    wait_done(base + 2, 800);
    bus.tx_start = 1'b0;
    chk("dec_a3_2", last_dec, 8'hA3);
    repeat (50) step();
    chk("b2b_frames", dec_cnt - dcnt0, 2);
    chk("b2b_dones", done_cnt - base, 2);

    // Request mid-DATA must be dropped.
    tick_per = 2 + int'($urandom_range(0, 3));
    base = done_cnt;
    send(8'h00);
    for (int i = 0; i < 2000 && dec_k < 60; i++) step();
    bus.din = 8'hFF;
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    bus.din = 8'($urandom);
    wait_done(base + 1, 1200);
    chk("dec_00", last_dec, 8'h00);
    repeat (300) step();
    chk("ignored_req", done_cnt - base, 1);

    // Reset at tick 70, then a clean 0x0F frame.
    tick_per = 3;
    base = done_cnt;
    dcnt0 = dec_cnt;
    send(8'hC6);
    for (int i = 0; i < 1000 && dec_k < 70; i++) step();
    reset = 1'b1;
    step();
    chk("rst_mid", {bus.tx, bus.busy}, 2'b10);
    reset = 1'b0;
    repeat (20) step();
    chk("rst_no_frame", dec_cnt - dcnt0, 0);
    send(8'h0F);
    wait_done(base + 1, 700);
    chk("dec_0f", last_dec, 8'h0F);

    // Random bytes, tick rates, gaps and stray requests while busy.
    for (int f = 0; f < 6; f++) begin
      tick_per = 1 + int'($urandom_range(0, 4));
      d = 8'($urandom);
      base = done_cnt;
      repeat ($urandom_range(0, 20)) step();
      send(d);
      for (int j = 0; j < 3; j++) begin
        repeat ($urandom_range(5, 100)) step();
        bus.din = 8'($urandom);
        bus.tx_start = (done_cnt == base);
        step();
        bus.tx_start = 1'b0;
      end
      wait_done(base + 1, 900);
      chk("dec_rand", last_dec, d);
    end

    // Baud-generator pacing: TICK every 325 CLKs, 0x41.
    tick_per = 325;
    base = done_cnt;
    send(8'h41);
    wait_done(base + 1, 53000);
    chk("lat_325", last_done_cyc - last_acc_cyc, FRAME * 325);
    chk("dec_41", last_dec, 8'h41);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
